// File: rtl/uart_tx_stage_if.sv
// Byte handshake between the byte source and the UART transmit stage.
// The source (master) drives tx_data/tx_valid; the stage (slave) answers with tx_ready.
interface uart_tx_stage_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_stage.sv
// 8N1 UART transmit stage: one byte per valid/ready handshake, LSB first.
// tx, busy and frame_count are registered from the next-state decode so the
// line changes on the same edge the state does; tx_ready is combinational.
// ena low freezes every register so a paused frame resumes without loss.
module uart_tx_stage #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  uart_tx_stage_if.slave bus,
  output logic           tx,
  output logic           busy,
  output logic [7:0]     frame_count
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] baud_r, baud_nxt_s;
  logic [2:0]  bit_r, bit_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic [7:0]  count_r, count_nxt_s;
  logic        tx_r, tx_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        ready_s, accept_s, bit_end_s;

  assign ready_s      = ena && (state_r == ST_IDLE);
  assign accept_s     = ready_s && bus.tx_valid;
  assign bit_end_s    = (baud_r == BAUD_LAST);
  assign bus.tx_ready = ready_s;

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign frame_count = count_r;

  // Next-state, counter and shift-register decode; everything holds while ena is low.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    count_nxt_s = count_r;
    if (ena) begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = ST_START;
            shift_nxt_s = bus.tx_data;
            baud_nxt_s  = 16'd0;
            bit_nxt_s   = 3'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_nxt_s = ST_DATA;
            baud_nxt_s  = 16'd0;
            bit_nxt_s   = 3'd0;
          end else begin
            baud_nxt_s = baud_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_nxt_s  = 16'd0;
            shift_nxt_s = {1'b0, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_nxt_s = ST_STOP;
              bit_nxt_s   = 3'd0;
            end else begin
              bit_nxt_s = bit_r + 3'd1;
            end
          end else begin
            baud_nxt_s = baud_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            state_nxt_s = ST_IDLE;
            baud_nxt_s  = 16'd0;
            count_nxt_s = count_r + 8'd1;
          end else begin
            baud_nxt_s = baud_r + 16'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          baud_nxt_s  = 16'd0;
          bit_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      baud_nxt_s  = baud_r;
    end
  end

  // Line level and busy flag for the state being entered, so they align with it.
  always_comb begin
    tx_nxt_s   = tx_r;
    busy_nxt_s = busy_r;
    if (ena) begin
      case (state_nxt_s)
        ST_START: tx_nxt_s = 1'b0;
        ST_DATA:  tx_nxt_s = shift_nxt_s[0];
        default:  tx_nxt_s = 1'b1;
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE);
    end else begin
      tx_nxt_s   = tx_r;
      busy_nxt_s = busy_r;
    end
  end

  // State, counters, shift register and output registers; reset forces the line idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      count_r <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      count_r <= count_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage: a C=4 instance for framing, handshake,
// pause and reset scenarios, and a C=2 instance for the frame counter wrap.
module tb_uart_tx_stage;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       tx4, busy4;
  logic [7:0] fc4;
  logic       tx2, busy2;
  logic [7:0] fc2;

  int tests_run;
  int tests_failed;

  uart_tx_stage_if if4 ();
  uart_tx_stage_if if2 ();

  uart_tx_stage #(.CLKS_PER_BIT(C)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if4.slave),
    .tx(tx4), .busy(busy4), .frame_count(fc4)
  );

  uart_tx_stage #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if2.slave),
    .tx(tx2), .busy(busy2), .frame_count(fc2)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    ena          = 1'b1;
    if4.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
    if4.tx_data  = 8'h00;
    if2.tx_data  = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    ena          = 1'b1;
    if4.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
    if4.tx_data  = 8'h00;
    if2.tx_data  = 8'h00;
    repeat (5) step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (tx4 !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx4); end
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    tests_run++;
    if (fc4 !== 8'd0) begin tests_failed++; $display("FAIL reset_frame_count: got %0d expected 0", fc4); end
    tests_run++;
    if (if4.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b expected 1", if4.tx_ready); end
  endtask

  task automatic test_single_frame();
    logic [9:0] frm;
    int busy_cnt;
    frm = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    do_reset();
    if4.tx_data  = 8'hA5;
    if4.tx_valid = 1'b1;
    step();
    if4.tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      if (busy4 === 1'b1) busy_cnt++;
      tests_run++;
      if (tx4 !== frm[i / 4]) begin
        tests_failed++;
        $display("FAIL single_tx cycle %0d: got %b expected %b", i, tx4, frm[i / 4]);
      end
    end
    step();
    if (busy4 === 1'b1) busy_cnt++;
    tests_run++;
    if (busy_cnt != 40) begin tests_failed++; $display("FAIL single_busy_len: got %0d expected 40", busy_cnt); end
    tests_run++;
    if (fc4 !== 8'd1) begin tests_failed++; $display("FAIL single_frame_count: got %0d expected 1", fc4); end
    tests_run++;
    if (if4.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready_after: got %b expected 1", if4.tx_ready); end
    tests_run++;
    if (tx4 !== 1'b1) begin tests_failed++; $display("FAIL single_tx_idle: got %b expected 1", tx4); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] frm1, frm2;
    logic       exp_tx, exp_rdy;
    frm1 = {1'b1, 8'h00, 1'b0};
    frm2 = {1'b1, 8'hFF, 1'b0};
    do_reset();
    if4.tx_data  = 8'h00;
    if4.tx_valid = 1'b1;
    step();
    // Source moves on to the next byte while the first frame is in flight.
    if4.tx_data = 8'hFF;
    for (int i = 0; i <= 80; i++) begin
      if (i > 0) step();
      if (i < 40) begin
        exp_tx  = frm1[i / 4];
        exp_rdy = 1'b0;
      end else if (i == 40) begin
        exp_tx  = 1'b1;
        exp_rdy = 1'b1;
      end else begin
        exp_tx  = frm2[(i - 41) / 4];
        exp_rdy = 1'b0;
      end
      tests_run++;
      if (tx4 !== exp_tx) begin
        tests_failed++;
        $display("FAIL b2b_tx cycle %0d: got %b expected %b", i, tx4, exp_tx);
      end
      tests_run++;
      if (if4.tx_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL b2b_ready cycle %0d: got %b expected %b", i, if4.tx_ready, exp_rdy);
      end
      if (i == 41) if4.tx_valid = 1'b0;
    end
    step();
    tests_run++;
    if (fc4 !== 8'd2) begin tests_failed++; $display("FAIL b2b_frame_count: got %0d expected 2", fc4); end
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end: got %b expected 0", busy4); end
  endtask

  task automatic test_ena_pause();
    logic [9:0] frm;
    int         j;
    frm = {1'b1, 8'h5A, 1'b0};
    do_reset();
    // Disabled while idle: no ready, no accept even with valid high.
    ena          = 1'b0;
    if4.tx_data  = 8'h5A;
    if4.tx_valid = 1'b1;
    step();
    step();
    tests_run++;
    if (if4.tx_ready !== 1'b0) begin tests_failed++; $display("FAIL pause_idle_ready: got %b expected 0", if4.tx_ready); end
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL pause_idle_busy: got %b expected 0", busy4); end
    ena = 1'b1;
    step();
    if4.tx_valid = 1'b0;
    for (int i = 0; i < 47; i++) begin
      if (i > 0) step();
      if (i < 18) j = i;
      else if (i < 25) j = 17;
      else j = i - 7;
      tests_run++;
      if (tx4 !== frm[j / 4]) begin
        tests_failed++;
        $display("FAIL pause_tx cycle %0d: got %b expected %b", i, tx4, frm[j / 4]);
      end
      if (i >= 18 && i <= 24) begin
        tests_run++;
        if (if4.tx_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL pause_ready cycle %0d: got %b expected 0", i, if4.tx_ready);
        end
      end
      if (i == 17) ena = 1'b0;
      if (i == 24) ena = 1'b1;
    end
    step();
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL pause_busy_end: got %b expected 0", busy4); end
    tests_run++;
    if (fc4 !== 8'd1) begin tests_failed++; $display("FAIL pause_frame_count: got %0d expected 1", fc4); end
  endtask

  task automatic test_async_reset();
    logic [9:0] frm;
    frm = {1'b1, 8'h3C, 1'b0};
    do_reset();
    if4.tx_data  = 8'hFF;
    if4.tx_valid = 1'b1;
    step();
    if4.tx_valid = 1'b0;
    repeat (40) step();
    tests_run++;
    if (fc4 !== 8'd1) begin tests_failed++; $display("FAIL arst_pre_count: got %0d expected 1", fc4); end
    if4.tx_data  = 8'h00;
    if4.tx_valid = 1'b1;
    step();
    if4.tx_valid = 1'b0;
    repeat (13) step();
    tests_run++;
    if (tx4 !== 1'b0) begin tests_failed++; $display("FAIL arst_bit2_low: got %b expected 0", tx4); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tx4 !== 1'b1) begin tests_failed++; $display("FAIL arst_tx_immediate: got %b expected 1", tx4); end
    tests_run++;
    if (fc4 !== 8'd0) begin tests_failed++; $display("FAIL arst_frame_count: got %0d expected 0", fc4); end
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL arst_busy: got %b expected 0", busy4); end
    step();
    rst_n = 1'b1;
    step();
    if4.tx_data  = 8'h3C;
    if4.tx_valid = 1'b1;
    step();
    if4.tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      tests_run++;
      if (tx4 !== frm[i / 4]) begin
        tests_failed++;
        $display("FAIL arst_post_tx cycle %0d: got %b expected %b", i, tx4, frm[i / 4]);
      end
    end
    step();
    tests_run++;
    if (fc4 !== 8'd1) begin tests_failed++; $display("FAIL arst_post_count: got %0d expected 1", fc4); end
  endtask

  task automatic test_wrap();
    do_reset();
    if2.tx_data  = 8'h81;
    if2.tx_valid = 1'b1;
    step();
    for (int i = 1; i <= 5396; i++) begin
      step();
      if (i == 20) begin
        tests_run++;
        if (fc2 !== 8'd1) begin tests_failed++; $display("FAIL wrap_first: got %0d expected 1", fc2); end
      end
      if (i == 5374) begin
        tests_run++;
        if (fc2 !== 8'd255) begin tests_failed++; $display("FAIL wrap_255: got %0d expected 255", fc2); end
      end
      if (i == 5375) begin
        tests_run++;
        if (fc2 !== 8'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d expected 0", fc2); end
        tests_run++;
        if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL wrap_busy: got %b expected 0", busy2); end
      end
    end
    tests_run++;
    if (fc2 !== 8'd1) begin tests_failed++; $display("FAIL wrap_257th: got %0d expected 1", fc2); end
    if2.tx_valid = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    ena          = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ena_pause();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_stage.md
# uart_tx_stage

Serial transmit stage inside `tt_um_shnitta_tinytapeout_handson_ttsky`, downstream of the byte source driven from `ui_in`/`uio_in`. It accepts one byte per valid/ready handshake and emits it as an 8N1 UART frame on a single output pin (mapped to `uo_out[0]`). A running count of completed frames is exposed for bring-up on the remaining `uo_out` bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200 baud). Legal range 2..65535.

Ports (`clk` and `rst_n` names match the top level):
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: design-select enable. When low, the block freezes.
- `tx_data` input 8: byte to send. Sampled only on the accept edge.
- `tx_valid` input 1: the source has a byte on `tx_data`.
- `tx_ready` output 1: the block can accept a byte. Combinational: `ena` high and state is IDLE.
- `tx` output 1: serial line. Idle level is 1. Registered.
- `busy` output 1: high in START, DATA and STOP. Registered.
- `frame_count` output 8: number of frames completed, mod 256. Registered.

## Operation
- Reset (asynchronous assert, synchronous release):
  - `tx`=1, `busy`=0, `frame_count`=0.
  - State is IDLE; bit counter and baud counter are 0.
  - The shift register is cleared.
- Accept: `tx_valid`=1 and `tx_ready`=1 at a rising edge.
  - `tx_data` is latched into the shift register.
  - The state moves to START.
- States:
  - IDLE: `tx`=1. On accept, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. The register shifts right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and increment `frame_count`.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. It reloads to 0 on every bit boundary and on accept.
- `frame_count` wraps from 255 to 0 with no flag.
- `tx_data` changes while the block is busy have no effect on the frame in flight.
- `tx_valid` held high while busy is not accepted and is not queued. It is accepted on the first IDLE cycle with `ena`=1.
- `ena`=0:
  - All registers hold, including the baud counter, state, `tx` and `frame_count`.
  - `tx_ready`=0, so no accept can happen.
  - When `ena` returns high, the frame resumes exactly where it stopped.
- Reset during a frame: `tx` returns to 1 immediately (asynchronously). The partial frame is abandoned and `frame_count` is cleared.

## Timing
- Accept at edge N:
  - `tx`=0 and `busy`=1 from edge N+1.
  - Start bit covers cycles N+1 .. N+C, where C=`CLKS_PER_BIT`.
- Data bit k (k = 0..7) occupies cycles N+1+C(k+1) .. N+C(k+2).
- Stop bit occupies cycles N+1+9C .. N+10C.
- Edge N+10C+1 (the first edge after the stop bit):
  - The state returns to IDLE.
  - `busy`=0 and `frame_count` increments.
  - `tx_ready`=1 in the cycle after that edge.
- Back-to-back bytes: the earliest next accept is edge N+10C+2. The minimum frame period is therefore 10C+1 cycles.
  - The `tx`=1 stop level continues through the IDLE cycle, so there is no glitch.
- All outputs are glitch-free registers except `tx_ready`, which is combinational from state and `ena`.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles with `ena`=1 → `tx`=1, `busy`=0, `frame_count`=0, `tx_ready`=1.
- Single frame, C=4: send 0xA5.
  - `tx` sequence in 4-cycle slots must be 0, 1,0,1,0,0,1,0,1, 1 (start, LSB first, stop).
  - `busy` high for exactly 40 cycles; `frame_count`=1 afterwards.
- Back-to-back, C=4: `tx_valid` held high with 0x00 then 0xFF.
  - The second start bit begins 41 cycles after the first.
  - `tx_ready` is low throughout the first frame.
  - `frame_count`=2 at the end.
- `ena` pause, C=4: drop `ena` for 7 cycles in the middle of data bit 3 of 0x5A.
  - `tx` holds its level for the pause.
  - The bit-3 slot stretches to 11 cycles; the rest of the frame is unchanged.
  - `tx_ready`=0 throughout the pause.
- Async reset mid-frame: assert `rst_n` low during data bit 2 → `tx`=1 within the same cycle, without waiting for a clock edge, and `frame_count`=0. After release, a new 0x3C frame transmits correctly.
- Wrap: complete 256 frames (C=2) → `frame_count` reads 0 and the 257th frame increments it to 1.
